crc_frame_checker: RTL and testbench

- Receive-side counterpart to the bit-serial CRC generator peripheral.
- Consumes a byte stream (payload followed by its appended CRC field) over a valid/ready handshake and updates a CRC register bit-serially, one bit per clock.
- At end of frame, reports pass/fail by the zero-residue rule: the register must be 0 after the CRC field has been shifted in.
- Sits between a byte-oriented receiver (UART/SPI front end) and the TinyQV register interface.

---
 rtl/crc_frame_checker.sv | 131 +++++++++++++
 tb/tb_crc_frame_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_checker.sv
// Receive-side CRC checker: shifts each accepted byte through the CRC register one bit
// per clock and flags the frame good when the register is zero after the CRC field.
module crc_frame_checker #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] poly,
    input  logic [WIDTH-1:0] init,
    input  logic             refin,
    input  logic             clear,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             short_err,
    output logic [WIDTH-1:0] crc_value
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] FULL = CW'(NBYTES);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] crc_reg;
    logic [WIDTH-1:0] poly_reg;
    logic             refin_reg;
    logic [7:0]       byte_reg;
    logic             last_reg;
    logic [2:0]       bit_cnt_reg;
    logic [CW-1:0]    byte_cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             crc_ok_reg;
    logic             short_err_reg;

    logic             bit_sel;
    logic             fb;
    logic [WIDTH-1:0] crc_next;

    assign bit_sel = refin_reg ? byte_reg[bit_cnt_reg] : byte_reg[3'd7 - bit_cnt_reg];
    assign fb      = crc_reg[WIDTH-1] ^ bit_sel;

    // One Galois-style LFSR step: shift left, fold in the polynomial when feedback is set.
    assign crc_next[0] = fb & poly_reg[0];
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_crc_step
            assign crc_next[gi] = crc_reg[gi-1] ^ (fb & poly_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            crc_reg       <= '0;
            poly_reg      <= '0;
            refin_reg     <= 1'b0;
            byte_reg      <= '0;
            last_reg      <= 1'b0;
            bit_cnt_reg   <= '0;
            byte_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            crc_ok_reg    <= 1'b0;
            short_err_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (clear) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (s_valid) begin
                            byte_reg    <= s_data;
                            last_reg    <= s_last;
                            bit_cnt_reg <= '0;
                            state_reg   <= SHIFT;
                            if (!busy_reg) begin
                                crc_reg      <= init;
                                poly_reg     <= poly;
                                refin_reg    <= refin;
                                byte_cnt_reg <= '0;
                                busy_reg     <= 1'b1;
                            end
                        end
                    end
                    SHIFT: begin
                        crc_reg     <= crc_next;
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            if (byte_cnt_reg != FULL) begin
                                byte_cnt_reg <= byte_cnt_reg + 1'b1;
                            end
                            if (last_reg) begin
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end
                    end
                    DONE: begin
                        crc_ok_reg    <= (crc_reg == '0) && (byte_cnt_reg == FULL);
                        short_err_reg <= (byte_cnt_reg < FULL);
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign s_ready   = (state_reg == IDLE) && !clear;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign crc_ok    = crc_ok_reg;
    assign short_err = short_err_reg;
    assign crc_value = crc_reg;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Directed bench for crc_frame_checker at WIDTH 32, 16 and 8 using known CRC check values.
module tb_crc_frame_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset   = 1'b0;
    logic       clear   = 1'b0;
    logic       refin   = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;
    logic [7:0] s_data  = 8'h00;
    int         sel     = 0;

    logic [31:0] poly32 = 32'h04C11DB7, init32 = 32'hFFFFFFFF;
    logic [15:0] poly16 = 16'h8005,     init16 = 16'h0000;
    logic [7:0]  poly8  = 8'h07,        init8  = 8'h00;

    logic        v32, v16, v8;
    logic        rdy32, rdy16, rdy8, busy32, busy16, busy8, done32, done16, done8;
    logic        ok32, ok16, ok8, sh32, sh16, sh8;
    logic [31:0] crc32;
    logic [15:0] crc16;
    logic [7:0]  crc8;

    assign v32 = s_valid && (sel == 0);
    assign v16 = s_valid && (sel == 1);
    assign v8  = s_valid && (sel == 2);

    logic cur_ready, cur_busy, cur_done, cur_ok, cur_short, cur_zero;
    assign cur_ready = (sel == 0) ? rdy32  : (sel == 1) ? rdy16  : rdy8;
    assign cur_busy  = (sel == 0) ? busy32 : (sel == 1) ? busy16 : busy8;
    assign cur_done  = (sel == 0) ? done32 : (sel == 1) ? done16 : done8;
    assign cur_ok    = (sel == 0) ? ok32   : (sel == 1) ? ok16   : ok8;
    assign cur_short = (sel == 0) ? sh32   : (sel == 1) ? sh16   : sh8;
    assign cur_zero  = (sel == 0) ? (crc32 == 32'h0) : (sel == 1) ? (crc16 == 16'h0) : (crc8 == 8'h0);

    crc_frame_checker #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .poly(poly32), .init(init32), .refin(refin), .clear(clear),
        .s_valid(v32), .s_data(s_data), .s_last(s_last), .s_ready(rdy32), .busy(busy32),
        .done(done32), .crc_ok(ok32), .short_err(sh32), .crc_value(crc32));

    crc_frame_checker #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .poly(poly16), .init(init16), .refin(refin), .clear(clear),
        .s_valid(v16), .s_data(s_data), .s_last(s_last), .s_ready(rdy16), .busy(busy16),
        .done(done16), .crc_ok(ok16), .short_err(sh16), .crc_value(crc16));

    crc_frame_checker #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .poly(poly8), .init(init8), .refin(refin), .clear(clear),
        .s_valid(v8), .s_data(s_data), .s_last(s_last), .s_ready(rdy8), .busy(busy8),
        .done(done8), .crc_ok(ok8), .short_err(sh8), .crc_value(crc8));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds s_valid high, scribbles on s_data/s_last while not ready, presents b once ready.
    task automatic send_byte(input logic [7:0] b, input logic last, output int waited);
        waited = 0;
        s_valid = 1'b1;
        while (!cur_ready && waited < 40) begin
            s_data = 8'($urandom);
            s_last = 1'($urandom);
            @(negedge clk);
            waited++;
        end
        if (!cur_ready) chk("ready_timeout", {31'h0, cur_ready}, 32'h1);
        s_data = b;
        s_last = last;
        @(negedge clk);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!cur_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", {31'h0, cur_done}, 32'h1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] q[$], input logic exp_ok,
                             input logic exp_short, input logic exp_zero, input logic timing);
        int w;
        int lat;
        foreach (q[i]) begin
            send_byte(q[i], (i == q.size() - 1), w);
            if (i == 0) begin
                chk({tag, "_busy_mid"}, {31'h0, cur_busy}, 32'h1);
                chk({tag, "_ready_in_shift"}, {31'h0, cur_ready}, 32'h0);
            end
            if (timing && i == 2) chk({tag, "_ready_gap"}, w, 32'd8);
        end
        s_valid = 1'b0;
        wait_done(lat);
        if (timing) chk({tag, "_done_latency"}, lat, 32'd8);
        chk({tag, "_crc_zero"}, {31'h0, cur_zero}, {31'h0, exp_zero});
        @(negedge clk);
        chk({tag, "_crc_ok"}, {31'h0, cur_ok}, {31'h0, exp_ok});
        chk({tag, "_short_err"}, {31'h0, cur_short}, {31'h0, exp_short});
        chk({tag, "_busy_end"}, {31'h0, cur_busy}, 32'h0);
        chk({tag, "_done_pulse"}, {31'h0, cur_done}, 32'h0);
        $display("frame %s: crc_ok=%0b short_err=%0b", tag, cur_ok, cur_short);
    endtask

    logic [7:0] good32[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                              8'h03, 8'h76, 8'hE6, 8'hE7};
    logic [7:0] bad32[$]  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h36, 8'h36, 8'h37, 8'h38, 8'h39,
                              8'h03, 8'h76, 8'hE6, 8'hE7};
    logic [7:0] good16[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                              8'h3D, 8'hBB};
    logic [7:0] good8[$]  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                              8'hF4};
    logic [7:0] one0[$]   = '{8'h00};

    initial begin
        int w;
        int lat;

        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, rdy32}, 32'h1);
        chk("rst_busy", {31'h0, busy32}, 32'h0);
        chk("rst_done", {31'h0, done32}, 32'h0);
        chk("rst_ok", {31'h0, ok32}, 32'h0);
        chk("rst_short", {31'h0, sh32}, 32'h0);
        chk("rst_crc", crc32, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        sel = 0; refin = 1'b0;
        run_frame("crc32_good", good32, 1'b1, 1'b0, 1'b1, 1'b1);
        run_frame("crc32_corrupt", bad32, 1'b0, 1'b0, 1'b0, 1'b0);

        sel = 1; refin = 1'b1;
        run_frame("crc16_arc", good16, 1'b1, 1'b0, 1'b1, 1'b0);

        sel = 2; refin = 1'b0;
        run_frame("crc8", good8, 1'b1, 1'b0, 1'b1, 1'b1);

        sel = 0;
        run_frame("crc32_short", one0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame("crc32_backpressure", good32, 1'b1, 1'b0, 1'b1, 1'b1);

        // Abort during the third byte; s_valid stays high across the clear.
        send_byte(8'h31, 1'b0, w);
        send_byte(8'h32, 1'b0, w);
        send_byte(8'h33, 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        s_data = 8'h34;
        clear = 1'b1;
        @(negedge clk);
        chk("clear_busy", {31'h0, busy32}, 32'h0);
        chk("clear_ready", {31'h0, rdy32}, 32'h0);
        chk("clear_done", {31'h0, done32}, 32'h0);
        @(negedge clk);
        clear = 1'b0;
        s_valid = 1'b0;
        chk("clear_no_accept", {31'h0, busy32}, 32'h0);
        chk("clear_ok_kept", {31'h0, ok32}, 32'h1);
        repeat (10) begin
            @(negedge clk);
            if (done32) chk("clear_spurious_done", {31'h0, done32}, 32'h0);
        end
        run_frame("crc32_after_clear", good32, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset while shifting the second byte.
        send_byte(8'h31, 1'b0, w);
        send_byte(8'h32, 1'b0, w);
        @(negedge clk);
        s_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_ready", {31'h0, rdy32}, 32'h1);
        chk("midrst_crc", crc32, 32'h0);
        chk("midrst_busy", {31'h0, busy32}, 32'h0);
        chk("midrst_done", {31'h0, done32}, 32'h0);
        chk("midrst_ok", {31'h0, ok32}, 32'h0);
        chk("midrst_short", {31'h0, sh32}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_frame("crc32_after_reset", good32, 1'b1, 1'b0, 1'b1, 1'b0);

        lat = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
